// File: rtl/pll_clk_monitor.sv
// PLL output clock monitor.
// Samples a PLL clock in the sys_clk domain. While the PLL reports lock, it
// counts rising edges and high samples over fixed windows. After each window
// it reports both counts and a pass/fail flag for the edge count.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | no lock seen, counters held clear
// SETTLE  | lock seen, waiting SETTLE_CYC cycles before the first window
// MEASURE | window open, accumulating edges and high samples
// REPORT  | one-cycle gap, new results presented with meas_valid
`timescale 1ns/1ps
module pll_clk_monitor #(
    parameter int GATE_CYC   = 1000,
    parameter int SETTLE_CYC = 100,
    parameter int EXP_EDGES  = 250,
    parameter int TOL        = 2,
    parameter int CNT_W      = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_test,
    input  logic             locked,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             meas_ok,
    output logic             busy
);

    localparam int SET_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int LO_EDGE = (EXP_EDGES > TOL) ? (EXP_EDGES - TOL) : 0;
    localparam int HI_EDGE = EXP_EDGES + TOL;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             t_s1_q, t_s2_q, t_s3_q;
    logic             l_s1_q, l_s2_q;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0] edge_acc_q, edge_acc_d;
    logic [CNT_W-1:0] high_acc_q, high_acc_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic             ok_q, ok_d;
    logic             valid_q, valid_d;
    logic             rise;
    logic [CNT_W-1:0] edge_sum, high_sum;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
        return (inc && (a != {CNT_W{1'b1}})) ? (a + CNT_W'(1)) : a;
    endfunction

    function automatic logic in_range(input logic [CNT_W-1:0] cnt);
        logic [CNT_W:0] c;
        c = {1'b0, cnt};
        return (c >= (CNT_W+1)'(LO_EDGE)) && (c <= (CNT_W+1)'(HI_EDGE));
    endfunction

    // Two-flop synchronizers for clk_test and locked, plus the edge-detect stage.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            t_s1_q <= 1'b0;
            t_s2_q <= 1'b0;
            t_s3_q <= 1'b0;
            l_s1_q <= 1'b0;
            l_s2_q <= 1'b0;
        end else begin
            t_s1_q <= clk_test;
            t_s2_q <= t_s1_q;
            t_s3_q <= t_s2_q;
            l_s1_q <= locked;
            l_s2_q <= l_s1_q;
        end
    end

    assign rise     = t_s2_q & ~t_s3_q;
    assign edge_sum = sat_inc(edge_acc_q, rise);
    assign high_sum = sat_inc(high_acc_q, t_s2_q);

    // State, counter and result registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            gate_q     <= '0;
            edge_acc_q <= '0;
            high_acc_q <= '0;
            edge_cnt_q <= '0;
            high_cnt_q <= '0;
            ok_q       <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            gate_q     <= gate_d;
            edge_acc_q <= edge_acc_d;
            high_acc_q <= high_acc_d;
            edge_cnt_q <= edge_cnt_d;
            high_cnt_q <= high_cnt_d;
            ok_q       <= ok_d;
            valid_q    <= valid_d;
        end
    end

    // Next state. Lock loss overrides everything, including a window that completes on the same cycle.
    // Results are loaded on entry to REPORT, so they are visible while meas_valid is high.
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        gate_d     = gate_q;
        edge_acc_d = edge_acc_q;
        high_acc_d = high_acc_q;
        edge_cnt_d = edge_cnt_q;
        high_cnt_d = high_cnt_q;
        ok_d       = ok_q;
        valid_d    = 1'b0;
        if (!l_s2_q) begin
            state_d    = IDLE;
            settle_d   = '0;
            gate_d     = '0;
            edge_acc_d = '0;
            high_acc_d = '0;
            ok_d       = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d    = SETTLE;
                    settle_d   = '0;
                    gate_d     = '0;
                    edge_acc_d = '0;
                    high_acc_d = '0;
                end
                SETTLE: begin
                    if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                        state_d    = MEASURE;
                        settle_d   = '0;
                        gate_d     = '0;
                        edge_acc_d = '0;
                        high_acc_d = '0;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                MEASURE: begin
                    edge_acc_d = edge_sum;
                    high_acc_d = high_sum;
                    if (gate_q == CNT_W'(GATE_CYC - 1)) begin
                        state_d    = REPORT;
                        edge_cnt_d = edge_sum;
                        high_cnt_d = high_sum;
                        ok_d       = in_range(edge_sum);
                        valid_d    = 1'b1;
                    end else begin
                        gate_d = gate_q + CNT_W'(1);
                    end
                end
                REPORT: begin
                    state_d    = MEASURE;
                    gate_d     = '0;
                    edge_acc_d = '0;
                    high_acc_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign edge_cnt   = edge_cnt_q;
    assign high_cnt   = high_cnt_q;
    assign meas_valid = valid_q;
    assign meas_ok    = ok_q;
    assign busy       = (state_q == SETTLE) || (state_q == MEASURE);

endmodule

// File: tb/tb_pll_clk_monitor.sv
// Testbench for pll_clk_monitor.
// A reference model predicts each completed window from the sampled clk_test
// and locked history. The model pushes its predictions into a scoreboard.
// A monitor pops and compares an entry on every meas_valid.
`timescale 1ns/1ps
module tb_pll_clk_monitor;

    localparam int G    = 1000;
    localparam int S    = 100;
    localparam int EXP  = 250;
    localparam int TOL  = 2;
    localparam int W    = 16;
    localparam int NMAX = 65536;

    logic         sys_clk;
    logic         sys_rst_n;
    logic         clk_test;
    logic         locked;
    logic [W-1:0] edge_cnt;
    logic [W-1:0] high_cnt;
    logic         meas_valid;
    logic         meas_ok;
    logic         busy;

    typedef struct {
        int edges;
        int highs;
        int ok;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   in_h [0:NMAX-1];
    bit   lk_h [0:NMAX-1];
    int   last_edges = 0;
    int   last_highs = 0;
    int   last_ok = 0;

    // Waveform controls for the clk_test generator.
    bit   stuck_en = 0;
    bit   stuck_val = 0;
    bit   rnd = 0;
    int   hi_len = 2;
    int   lo_len = 2;

    pll_clk_monitor #(
        .GATE_CYC(G), .SETTLE_CYC(S), .EXP_EDGES(EXP), .TOL(TOL), .CNT_W(W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clk_test  (clk_test),
        .locked    (locked),
        .edge_cnt  (edge_cnt),
        .high_cnt  (high_cnt),
        .meas_valid(meas_valid),
        .meas_ok   (meas_ok),
        .busy      (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // 20 ns system clock.
    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    // clk_test changes only on falling sys_clk edges, so every level is sampled deterministically.
    initial begin
        int ph;
        ph = 0;
        clk_test = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (stuck_en) begin
                clk_test = stuck_val;
                ph = 0;
            end else if (ph <= 1) begin
                clk_test = ~clk_test;
                if (rnd) ph = int'($urandom_range(1, 3));
                else     ph = clk_test ? hi_len : lo_len;
            end else begin
                ph--;
            end
        end
    end

    // Reference model.
    // Lock must have been seen for one IDLE cycle plus S settle cycles.
    // Windows of G cycles then follow, each one separated by a 1-cycle report gap.
    // Edges and high samples are counted from the sampled clk_test history, delayed by the synchronizer.
    initial begin
        bit run;
        int a;
        run = 0;
        a = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            cyc++;
            if (cyc >= NMAX) begin
                $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cyc, NMAX);
                $fatal(1);
            end
            in_h[cyc] = sys_rst_n ? clk_test : 1'b0;
            lk_h[cyc] = sys_rst_n ? locked : 1'b0;
            if (!sys_rst_n) begin
                run = 0;
            end else if (!lk_h[cyc-1]) begin
                run = 0;
            end else begin
                if (!run) begin
                    run = 1;
                    a = cyc;
                end
                if (cyc >= a + S + 1 && ((cyc - (a + S + 1)) % (G + 1)) == G - 1) begin
                    exp_t e;
                    e.edges = 0;
                    e.highs = 0;
                    for (int c = cyc - G + 1; c <= cyc; c++) begin
                        if (in_h[c-1] && !in_h[c-2]) e.edges++;
                        if (in_h[c-1]) e.highs++;
                    end
                    e.ok  = (e.edges >= EXP - TOL && e.edges <= EXP + TOL) ? 1 : 0;
                    e.cyc = cyc + 1;
                    sb.push_back(e);
                end
            end
        end
    end

    // Monitor: every meas_valid must match the oldest prediction, including the cycle it appears on.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (meas_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_meas_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("edge_cnt", int'(edge_cnt), e.edges);
                    chk("high_cnt", int'(high_cnt), e.highs);
                    chk("meas_ok", int'(meas_ok), e.ok);
                    chk("valid_cycle", cyc, e.cyc);
                    last_edges = e.edges;
                    last_highs = e.highs;
                    last_ok    = e.ok;
                end
            end
        end
    end

    task automatic wait_valids(input int n, input int budget, input string name);
        int got;
        got = 0;
        for (int i = 0; i < budget && got < n; i++) begin
            @(negedge sys_clk);
            if (meas_valid === 1'b1) got++;
        end
        chk(name, got, n);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_edge_cnt"}, int'(edge_cnt), 0);
        chk({tag, "_high_cnt"}, int'(high_cnt), 0);
        chk({tag, "_meas_ok"}, int'(meas_ok), 0);
        chk({tag, "_meas_valid"}, int'(meas_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Directed scenarios, followed by randomized waveforms and lock drops.
    initial begin
        int d;
        sys_rst_n = 1'b0;
        locked    = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk_all_zero("reset");
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("idle_busy", int'(busy), 0);

        // 80 ns clock at 50% duty.
        hi_len = 2; lo_len = 2;
        wait_valids(2, 3000, "t1_timeout");

        // Lock dropped for 10 cycles mid-window. Counts hold and meas_ok clears.
        repeat (400) @(negedge sys_clk);
        chk("drop_busy_before", int'(busy), 1);
        chk("drop_ok_before", int'(meas_ok), last_ok);
        locked = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("drop_ok_cleared", int'(meas_ok), 0);
        chk("drop_busy", int'(busy), 0);
        repeat (7) @(negedge sys_clk);
        chk("drop_edge_held", int'(edge_cnt), last_edges);
        chk("drop_high_held", int'(high_cnt), last_highs);
        locked = 1'b1;
        wait_valids(1, 1500, "relock_timeout");

        // 160 ns clock: about 125 edges per window.
        hi_len = 4; lo_len = 4;
        wait_valids(2, 2500, "t2_timeout");

        // 200 ns clock with 40 ns high: 100 edges and 200 high samples per window.
        hi_len = 2; lo_len = 8;
        wait_valids(2, 2500, "t3_timeout");

        // Reset pulse mid-window.
        repeat (300) @(negedge sys_clk);
        chk("rst_busy_before", int'(busy), 1);
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("rst_pulse");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("rst_restart_busy", int'(busy), 0);
        hi_len = 2; lo_len = 2;
        wait_valids(1, 1500, "rst_timeout");

        // clk_test stuck high, then stuck low.
        stuck_en = 1; stuck_val = 1;
        wait_valids(2, 2500, "stuck1_timeout");
        stuck_val = 0;
        wait_valids(2, 2500, "stuck0_timeout");
        stuck_en = 0;

        // Random levels averaging 4 cycles per period. Edge counts fall on both sides of the tolerance band.
        rnd = 1;
        wait_valids(6, 7000, "rand_timeout");
        for (int k = 0; k < 3; k++) begin
            repeat (int'($urandom_range(50, 1500))) @(negedge sys_clk);
            d = int'($urandom_range(1, 3));
            locked = 1'b0;
            repeat (d) @(negedge sys_clk);
            locked = 1'b1;
            repeat (3 - d) @(negedge sys_clk);
            chk("rdrop_ok_cleared", int'(meas_ok), 0);
            chk("rdrop_busy", int'(busy), 0);
            wait_valids(1, 1500, "rdrop_timeout");
        end
        wait_valids(2, 2500, "rand_end_timeout");

        repeat (3) @(negedge sys_clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
